kmp_string_matcher: RTL and testbench

- Consumes the per-index failure-function vector produced by the failure-function block, plus the same pattern.
- Scans a streamed text, one byte per accepted beat, and reports every start position where the pattern occurs, overlapping matches included.
- Sits downstream of the failure-function block in the SME datapath: it is the reader of the failure-function table that block writes.

---
 rtl/SME_spec_param.sv | 16 +
 rtl/kmp_char_compare.sv | 26 ++
 rtl/kmp_string_matcher.sv | 116 +++++++++++
 tb/tb_kmp_string_matcher.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/SME_spec_param.sv
// Shared constants and state encodings for the string-matching engine datapath.
package SME_spec_param;

    localparam int BYTE        = 8;   // bits per character
    localparam int MAX_PATTERN = 8;   // maximum pattern length in characters
    localparam int MAX_PAT_ADD = 3;   // index width into the pattern
    localparam int STR_ADD     = 16;  // text position counter width

    // One-hot scan states.
    typedef enum logic [2:0] {
        IDLE_ST = 3'b001,
        SCAN_ST = 3'b010,
        DONE_ST = 3'b100
    } state_t;

endpackage

// File: rtl/kmp_char_compare.sv
// Selects pattern[j] and the fallback index ff[j-1], compares the pattern
// character against the incoming text character, and flags the last index.
module kmp_char_compare
    import SME_spec_param::*;
(
    input  logic [MAX_PATTERN*BYTE-1:0]        pattern,
    input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func,
    input  logic [MAX_PAT_ADD-1:0]             j,
    input  logic [MAX_PAT_ADD-1:0]             last_pat_idx,
    input  logic [BYTE-1:0]                    text_char,
    output logic                               hit,
    output logic [MAX_PAT_ADD-1:0]             fb_idx,
    output logic                               is_last
);

    logic [MAX_PAT_ADD-1:0] j_prev;

    // Compare against pattern[j]; fallback index is only meaningful when j > 0.
    always_comb begin
        j_prev  = j - 1'b1;
        hit     = (pattern[j*BYTE +: BYTE] == text_char);
        fb_idx  = (j == '0) ? '0 : fail_func[j_prev*MAX_PAT_ADD +: MAX_PAT_ADD];
        is_last = (j == last_pat_idx);
    end

endmodule

// File: rtl/kmp_string_matcher.sv
// Streaming KMP matcher: walks the text one accepted byte per cycle using a
// precomputed failure-function table and reports every (overlapping) match.
module kmp_string_matcher
    import SME_spec_param::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_valid,
    input  logic                               i_ff_valid,
    input  logic [MAX_PATTERN*BYTE-1:0]        pattern,
    input  logic [MAX_PAT_ADD-1:0]             last_pat_idx,
    input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] i_fail_func,
    input  logic [BYTE-1:0]                    i_char,
    input  logic                               i_char_valid,
    input  logic                               i_char_last,
    output logic                               o_char_ready,
    output logic                               o_match,
    output logic [STR_ADD-1:0]                 o_match_pos,
    output logic [STR_ADD-1:0]                 o_match_cnt,
    output logic                               o_done,
    output logic [2:0]                         dbg_state
);

    // Handshake: a text beat is accepted on a rising clk edge where both
    // i_char_valid and o_char_ready are high. o_char_ready is low during a
    // fallback stall, so the same character must be held and is re-compared.

    state_t                 state, state_nxt;
    logic [MAX_PAT_ADD-1:0] j;
    logic [STR_ADD-1:0]     pos;
    logic                   hit, is_last;
    logic [MAX_PAT_ADD-1:0] fb_idx;
    logic [MAX_PAT_ADD-1:0] ff_last;
    logic                   accept;

    kmp_char_compare u_cmp (
        .pattern      (pattern),
        .fail_func    (i_fail_func),
        .j            (j),
        .last_pat_idx (last_pat_idx),
        .text_char    (i_char),
        .hit          (hit),
        .fb_idx       (fb_idx),
        .is_last      (is_last)
    );

    assign ff_last      = i_fail_func[last_pat_idx*MAX_PAT_ADD +: MAX_PAT_ADD];
    assign o_char_ready = (state == SCAN_ST) && ((j == '0) || hit);
    assign accept       = o_char_ready && i_char_valid;
    assign o_done       = (state == DONE_ST);
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE_ST;
        else       state <= state_nxt;
    end

    // Next-state logic; dropping i_valid aborts a scan or releases DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_ST: if (i_valid && i_ff_valid) state_nxt = SCAN_ST;
            SCAN_ST: begin
                if (!i_valid)                      state_nxt = IDLE_ST;
                else if (accept && i_char_last)    state_nxt = DONE_ST;
            end
            DONE_ST: if (!i_valid) state_nxt = IDLE_ST;
            default: state_nxt = IDLE_ST;
        endcase
    end

    // Pattern index, text position and match reporting registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j           <= '0;
            pos         <= '0;
            o_match     <= 1'b0;
            o_match_pos <= '0;
            o_match_cnt <= '0;
        end else begin
            o_match <= 1'b0;
            case (state)
                IDLE_ST: begin
                    if (i_valid && i_ff_valid) begin
                        j           <= '0;
                        pos         <= '0;
                        o_match_cnt <= '0;
                    end
                end
                SCAN_ST: begin
                    if (i_valid && i_char_valid) begin
                        if (hit) begin
                            pos <= pos + 1'b1;
                            if (is_last) begin
                                o_match     <= 1'b1;
                                o_match_pos <= pos - {{(STR_ADD-MAX_PAT_ADD){1'b0}}, last_pat_idx};
                                if (o_match_cnt != '1) o_match_cnt <= o_match_cnt + 1'b1;
                                j <= ff_last;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end else if (j != '0) begin
                            // Stall: fall back and re-compare the same character.
                            j <= fb_idx;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kmp_string_matcher.sv
// Directed bench for the streaming KMP matcher with a match-position scoreboard.
module tb_kmp_string_matcher;
    import SME_spec_param::*;

    logic                               clk;
    logic                               reset;
    logic                               i_valid;
    logic                               i_ff_valid;
    logic [MAX_PATTERN*BYTE-1:0]        pattern;
    logic [MAX_PAT_ADD-1:0]             last_pat_idx;
    logic [MAX_PAT_ADD*MAX_PATTERN-1:0] i_fail_func;
    logic [BYTE-1:0]                    i_char;
    logic                               i_char_valid;
    logic                               i_char_last;
    logic                               o_char_ready;
    logic                               o_match;
    logic [STR_ADD-1:0]                 o_match_pos;
    logic [STR_ADD-1:0]                 o_match_cnt;
    logic                               o_done;
    logic [2:0]                         dbg_state;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    logic [STR_ADD-1:0] exp_q[$];

    kmp_string_matcher dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_ff_valid   (i_ff_valid),
        .pattern      (pattern),
        .last_pat_idx (last_pat_idx),
        .i_fail_func  (i_fail_func),
        .i_char       (i_char),
        .i_char_valid (i_char_valid),
        .i_char_last  (i_char_last),
        .o_char_ready (o_char_ready),
        .o_match      (o_match),
        .o_match_pos  (o_match_pos),
        .o_match_cnt  (o_match_cnt),
        .o_done       (o_done),
        .dbg_state    (dbg_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every o_match pulse must correspond to the next expected position.
    always @(negedge clk) begin
        if (!reset && o_match) begin
            if (exp_q.size() == 0) check("unexpected_match", 32'(o_match_pos), 32'hFFFF_FFFF);
            else                   check("match_pos", 32'(o_match_pos), 32'(exp_q.pop_front()));
        end
    end

    function automatic logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff4(input int f0, input int f1,
                                                               input int f2, input int f3);
        logic [MAX_PAT_ADD*MAX_PATTERN-1:0] v;
        v = '0;
        v[0*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(f0);
        v[1*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(f1);
        v[2*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(f2);
        v[3*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(f3);
        return v;
    endfunction

    // Driver: load a job and move into SCAN.
    task automatic start_job(input string pat, input logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff);
        pattern = '0;
        for (int k = 0; k < pat.len(); k++) pattern[k*BYTE +: BYTE] = pat[k];
        last_pat_idx = MAX_PAT_ADD'(pat.len() - 1);
        i_fail_func  = ff;
        i_valid      = 1'b1;
        i_ff_valid   = 1'b1;
        @(posedge clk); #1;
        check("enter_scan", 32'(dbg_state), 32'(SCAN_ST));
    endtask

    task automatic end_job();
        i_valid    = 1'b0;
        i_ff_valid = 1'b0;
        @(posedge clk); #1;
        check("back_idle", 32'(dbg_state), 32'(IDLE_ST));
    endtask

    // Driver: present one character until accepted, counting stall cycles.
    task automatic send_char(input logic [BYTE-1:0] c, input logic last);
        logic acc;
        int   tries;
        i_char       = c;
        i_char_valid = 1'b1;
        i_char_last  = last;
        tries        = 0;
        acc          = 1'b0;
        while (!acc && tries < 20) begin
            @(negedge clk);
            acc = o_char_ready;
            if (!acc) stalls++;
            @(posedge clk); #1;
            tries++;
        end
        if (!acc) check("accept_timeout", 32'(tries), 32'd0);
        i_char_valid = 1'b0;
        i_char_last  = 1'b0;
    endtask

    task automatic send_text(input string s, input logic with_last, input logic gaps);
        for (int k = 0; k < s.len(); k++) begin
            if (gaps) begin
                i_char_valid = 1'b0;
                i_char       = BYTE'($urandom_range(0, 255));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            send_char(s[k], with_last && (k == s.len() - 1));
        end
    endtask

    initial begin
        reset        = 1'b1;
        i_valid      = 1'b0;
        i_ff_valid   = 1'b0;
        pattern      = '0;
        last_pat_idx = '0;
        i_fail_func  = '0;
        i_char       = '0;
        i_char_valid = 1'b0;
        i_char_last  = 1'b0;

        // Reset state.
        #12;
        check("rst_state", 32'(dbg_state), 32'(IDLE_ST));
        check("rst_match", 32'(o_match), 32'd0);
        check("rst_pos", 32'(o_match_pos), 32'd0);
        check("rst_cnt", 32'(o_match_cnt), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // ABAB in ABABAB: overlapping matches at 0 and 2.
        start_job("ABAB", ff4(0, 0, 1, 2));
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd2);
        stalls = 0;
        send_text("ABABAB", 1'b1, 1'b0);
        check("abab_done", 32'(o_done), 32'd1);
        check("abab_cnt", 32'(o_match_cnt), 32'd2);
        check("abab_stalls", 32'(stalls), 32'd0);
        end_job();

        // Same job with random gaps between beats: same positions expected.
        start_job("ABAB", ff4(0, 0, 1, 2));
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd2);
        send_text("ABABAB", 1'b1, 1'b1);
        check("gaps_done", 32'(o_done), 32'd1);
        check("gaps_cnt", 32'(o_match_cnt), 32'd2);
        end_job();

        // AAB in AAAB: one fallback stall, match at 1.
        start_job("AAB", ff4(0, 1, 0, 0));
        exp_q.push_back(16'd1);
        stalls = 0;
        send_text("AAAB", 1'b1, 1'b0);
        check("aab_stalls", 32'(stalls), 32'd1);
        check("aab_cnt", 32'(o_match_cnt), 32'd1);
        end_job();

        // Single-character pattern A in BAAB.
        start_job("A", ff4(0, 0, 0, 0));
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        stalls = 0;
        send_text("BAAB", 1'b1, 1'b0);
        check("a_stalls", 32'(stalls), 32'd0);
        check("a_cnt", 32'(o_match_cnt), 32'd2);
        end_job();

        // Abort after three chars, then restart clears count and position.
        start_job("A", ff4(0, 0, 0, 0));
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        send_text("AAA", 1'b0, 1'b0);
        i_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'(dbg_state), 32'(IDLE_ST));
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_cnt", 32'(o_match_cnt), 32'd3);
        start_job("A", ff4(0, 0, 0, 0));
        check("restart_cnt", 32'(o_match_cnt), 32'd0);
        exp_q.push_back(16'd0);
        send_text("A", 1'b1, 1'b0);
        check("restart_cnt1", 32'(o_match_cnt), 32'd1);
        end_job();

        // XY in AXXY: final-beat match raises o_match and o_done together.
        start_job("XY", ff4(0, 0, 0, 0));
        exp_q.push_back(16'd2);
        stalls = 0;
        send_text("AXXY", 1'b1, 1'b0);
        check("xy_match", 32'(o_match), 32'd1);
        check("xy_done", 32'(o_done), 32'd1);
        check("xy_stalls", 32'(stalls), 32'd1);
        end_job();

        // Asynchronous reset between edges during SCAN.
        start_job("A", ff4(0, 0, 0, 0));
        send_text("B", 1'b0, 1'b0);
        send_char("A", 1'b0);
        check("pre_rst_match", 32'(o_match), 32'd1);
        check("pre_rst_pos", 32'(o_match_pos), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", 32'(dbg_state), 32'(IDLE_ST));
        check("arst_match", 32'(o_match), 32'd0);
        check("arst_pos", 32'(o_match_pos), 32'd0);
        check("arst_cnt", 32'(o_match_cnt), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        i_valid    = 1'b0;
        i_ff_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
